// File: rtl/ddr2_sdram_1_local_port_arbiter_if.sv
// ddr2_sdram_1_local_port_arbiter_if
// Bundles the two requester ports (p0_*/p1_*) and the DDR2 HP controller
// local interface (local_*) used by ddr2_sdram_1_local_port_arbiter.
//   slave  : arbiter view (takes port commands, drives controller commands)
//   master : environment view (requesters + controller model)
// Per port: read_req/write_req/address/size/wdata/be in, ack/wdata_req/
// rdata/rdata_valid out. Local: ready/wdata_req/rdata/rdata_valid in,
// read_req/write_req/burstbegin/address/size/wdata/be out.
interface ddr2_sdram_1_local_port_arbiter_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4
);
  logic              p0_read_req, p0_write_req, p0_ack, p0_wdata_req, p0_rdata_valid;
  logic [ADDR_W-1:0] p0_address;
  logic [1:0]        p0_size;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic [BE_W-1:0]   p0_be;

  logic              p1_read_req, p1_write_req, p1_ack, p1_wdata_req, p1_rdata_valid;
  logic [ADDR_W-1:0] p1_address;
  logic [1:0]        p1_size;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic [BE_W-1:0]   p1_be;

  logic              local_ready, local_read_req, local_write_req, local_burstbegin;
  logic [ADDR_W-1:0] local_address;
  logic [1:0]        local_size;
  logic [DATA_W-1:0] local_wdata, local_rdata;
  logic [BE_W-1:0]   local_be;
  logic              local_wdata_req, local_rdata_valid;

  modport slave (
    input  p0_read_req, p0_write_req, p0_address, p0_size, p0_wdata, p0_be,
    output p0_ack, p0_wdata_req, p0_rdata, p0_rdata_valid,
    input  p1_read_req, p1_write_req, p1_address, p1_size, p1_wdata, p1_be,
    output p1_ack, p1_wdata_req, p1_rdata, p1_rdata_valid,
    input  local_ready, local_wdata_req, local_rdata, local_rdata_valid,
    output local_read_req, local_write_req, local_burstbegin, local_address,
           local_size, local_wdata, local_be
  );

  modport master (
    output p0_read_req, p0_write_req, p0_address, p0_size, p0_wdata, p0_be,
    input  p0_ack, p0_wdata_req, p0_rdata, p0_rdata_valid,
    output p1_read_req, p1_write_req, p1_address, p1_size, p1_wdata, p1_be,
    input  p1_ack, p1_wdata_req, p1_rdata, p1_rdata_valid,
    output local_ready, local_wdata_req, local_rdata, local_rdata_valid,
    input  local_read_req, local_write_req, local_burstbegin, local_address,
           local_size, local_wdata, local_be
  );
endinterface

// File: rtl/ddr2_sdram_1_local_port_arbiter.sv
// ddr2_sdram_1_local_port_arbiter
// Two-port arbiter in front of the DDR2 HP controller local interface.
// Grants read/write commands (round-robin), issues them on local_* with
// local_burstbegin, and keeps read/write tag FIFOs of {port, beats} so that
// controller write-beat pulls and read-data beats are steered, in order, to
// the port that issued each command.
// Ports: clk, reset (async, active-high), bus (interface, slave modport).
// Optional: define DDR2_ARB_PORT0_PRIORITY_EN for fixed port-0 priority with
// a starvation guard (port 1 wins after 8 consecutive port-0 grants while it
// waits).
module ddr2_sdram_1_local_port_arbiter #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BE_W      = 4,
  parameter int unsigned TAG_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  ddr2_sdram_1_local_port_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(TAG_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, CMD} state_t;
  typedef struct packed {
    logic       port;
    logic [1:0] size;
  } tag_t;

  // ---------------- command FSM state ----------------
  state_t            state_q;
  logic              gnt_q, is_wr_q, rd_req_q, wr_req_q, bb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
`ifdef DDR2_ARB_PORT0_PRIORITY_EN
  logic [3:0]        starve_q;
`else
  logic              prio_q;   // port currently favoured
`endif

  // ---------------- tag FIFOs ----------------
  tag_t            rd_mem [TAG_DEPTH];
  tag_t            wr_mem [TAG_DEPTH];
  logic [PW-1:0]   rd_rptr_q, rd_wptr_q, wr_rptr_q, wr_wptr_q;
  logic [CW-1:0]   rd_cnt_q, wr_cnt_q;
  logic [1:0]      rd_beat_q, wr_beat_q;   // beats already consumed at head
  logic            wsel_q, wval_q;

  logic            rd_full, wr_full;
  logic [1:0]      rd_el, wr_el, port_el;
  logic            gnt_valid, gnt_port, gnt_is_wr;
  logic [ADDR_W-1:0] gnt_addr;
  logic [1:0]      gnt_size_raw, gnt_size;
  logic            accept, rd_push, wr_push;
  tag_t            rd_head, wr_head, push_tag;
  logic            rd_hit, wr_hit, rd_last, wr_last;
  logic [DATA_W-1:0] wdata_mux;
  logic [BE_W-1:0]   be_mux;

  assign rd_full = (rd_cnt_q == CW'(TAG_DEPTH));
  assign wr_full = (wr_cnt_q == CW'(TAG_DEPTH));

  // A full FIFO only masks its own command type.
  always_comb begin
    rd_el     = {bus.p1_read_req,  bus.p0_read_req}  & {2{~rd_full}};
    wr_el     = {bus.p1_write_req, bus.p0_write_req} & {2{~wr_full}};
    port_el   = rd_el | wr_el;
    gnt_valid = |port_el;
`ifdef DDR2_ARB_PORT0_PRIORITY_EN
    gnt_port  = port_el[1] && (!port_el[0] || (starve_q >= 4'd8));
`else
    gnt_port  = port_el[prio_q] ? prio_q : ~prio_q;
`endif
    gnt_is_wr    = wr_el[gnt_port];   // write wins when a port asks for both
    gnt_addr     = gnt_port ? bus.p1_address : bus.p0_address;
    gnt_size_raw = gnt_port ? bus.p1_size : bus.p0_size;
    gnt_size     = (gnt_size_raw == 2'd0) ? 2'd1 : gnt_size_raw;
  end

  // Ack is combinational with local_ready so the requester drops its request
  // before the FSM is back in IDLE; a registered ack would double-grant.
  assign accept   = (state_q == CMD) && bus.local_ready;
  assign rd_push  = accept && !is_wr_q;
  assign wr_push  = accept &&  is_wr_q;
  assign push_tag = '{port: gnt_q, size: size_q};

  assign bus.p0_ack = accept && !gnt_q;
  assign bus.p1_ack = accept &&  gnt_q;
  assign bus.local_read_req   = rd_req_q;
  assign bus.local_write_req  = wr_req_q;
  assign bus.local_burstbegin = bb_q;
  assign bus.local_address    = addr_q;
  assign bus.local_size       = size_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      is_wr_q  <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      bb_q     <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
`ifdef DDR2_ARB_PORT0_PRIORITY_EN
      starve_q <= '0;
`else
      prio_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            state_q  <= CMD;
            gnt_q    <= gnt_port;
            is_wr_q  <= gnt_is_wr;
            rd_req_q <= ~gnt_is_wr;
            wr_req_q <= gnt_is_wr;
            bb_q     <= 1'b1;
            addr_q   <= gnt_addr;
            size_q   <= gnt_size;
`ifdef DDR2_ARB_PORT0_PRIORITY_EN
            if (!gnt_port && port_el[1]) starve_q <= starve_q + 4'd1;
            else                         starve_q <= '0;
`endif
          end
        end
        CMD: begin
          bb_q <= 1'b0;
          if (bus.local_ready) begin
            state_q  <= IDLE;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
`ifndef DDR2_ARB_PORT0_PRIORITY_EN
            // Favour the other port next time; reset value 0 favours port 0.
            prio_q   <= ~gnt_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- tag FIFO storage ----------------
  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wptr_q] <= push_tag;
    if (wr_push) wr_mem[wr_wptr_q] <= push_tag;
  end

  assign rd_head = rd_mem[rd_rptr_q];
  assign wr_head = wr_mem[wr_rptr_q];
  assign rd_hit  = bus.local_rdata_valid && (rd_cnt_q != '0);
  assign wr_hit  = bus.local_wdata_req   && (wr_cnt_q != '0);
  assign rd_last = rd_hit && ((rd_beat_q + 2'd1) == rd_head.size);
  assign wr_last = wr_hit && ((wr_beat_q + 2'd1) == wr_head.size);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_rptr_q <= '0;
      rd_wptr_q <= '0;
      rd_cnt_q  <= '0;
      rd_beat_q <= '0;
      wr_rptr_q <= '0;
      wr_wptr_q <= '0;
      wr_cnt_q  <= '0;
      wr_beat_q <= '0;
      wsel_q    <= 1'b0;
      wval_q    <= 1'b0;
    end else begin
      if (rd_push) rd_wptr_q <= rd_wptr_q + PW'(1);
      if (rd_last) begin
        rd_rptr_q <= rd_rptr_q + PW'(1);
        rd_beat_q <= '0;
      end else if (rd_hit) begin
        rd_beat_q <= rd_beat_q + 2'd1;
      end
      unique case ({rd_push, rd_last})
        2'b10:   rd_cnt_q <= rd_cnt_q + CW'(1);
        2'b01:   rd_cnt_q <= rd_cnt_q - CW'(1);
        default: rd_cnt_q <= rd_cnt_q;
      endcase

      if (wr_push) wr_wptr_q <= wr_wptr_q + PW'(1);
      if (wr_last) begin
        wr_rptr_q <= wr_rptr_q + PW'(1);
        wr_beat_q <= '0;
      end else if (wr_hit) begin
        wr_beat_q <= wr_beat_q + 2'd1;
      end
      unique case ({wr_push, wr_last})
        2'b10:   wr_cnt_q <= wr_cnt_q + CW'(1);
        2'b01:   wr_cnt_q <= wr_cnt_q - CW'(1);
        default: wr_cnt_q <= wr_cnt_q;
      endcase

      // Port presents data the cycle after its wdata_req: remember who.
      wval_q <= wr_hit;
      if (wr_hit) wsel_q <= wr_head.port;
    end
  end

  // ---------------- steering ----------------
  assign bus.p0_wdata_req   = wr_hit && !wr_head.port;
  assign bus.p1_wdata_req   = wr_hit &&  wr_head.port;
  assign bus.p0_rdata_valid = rd_hit && !rd_head.port;
  assign bus.p1_rdata_valid = rd_hit &&  rd_head.port;
  assign bus.p0_rdata       = bus.local_rdata;
  assign bus.p1_rdata       = bus.local_rdata;

  always_comb begin
    wdata_mux = '0;
    be_mux    = '0;
    if (wval_q) begin
      wdata_mux = wsel_q ? bus.p1_wdata : bus.p0_wdata;
      be_mux    = wsel_q ? bus.p1_be    : bus.p0_be;
    end
  end

  assign bus.local_wdata = wdata_mux;
  assign bus.local_be    = be_mux;
endmodule

// File: tb/tb_ddr2_sdram_1_local_port_arbiter.sv
module tb_ddr2_sdram_1_local_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  ddr2_sdram_1_local_port_arbiter_if #(.ADDR_W(24), .DATA_W(32), .BE_W(4)) bus ();

  ddr2_sdram_1_local_port_arbiter #(
    .ADDR_W(24), .DATA_W(32), .BE_W(4), .TAG_DEPTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.p0_read_req = 0; bus.p0_write_req = 0; bus.p0_address = '0; bus.p0_size = '0;
    bus.p0_wdata = '0; bus.p0_be = '0;
    bus.p1_read_req = 0; bus.p1_write_req = 0; bus.p1_address = '0; bus.p1_size = '0;
    bus.p1_wdata = '0; bus.p1_be = '0;
    bus.local_ready = 1; bus.local_wdata_req = 0; bus.local_rdata = '0; bus.local_rdata_valid = 0;
    step(); step();

    // Reset state
    chk("rst_p0_ack", bus.p0_ack, 0);
    chk("rst_p1_ack", bus.p1_ack, 0);
    chk("rst_rd_req", bus.local_read_req, 0);
    chk("rst_wr_req", bus.local_write_req, 0);
    chk("rst_bb", bus.local_burstbegin, 0);
    chk("rst_addr", bus.local_address, 0);
    chk("rst_size", bus.local_size, 0);
    chk("rst_wdata", bus.local_wdata, 0);
    chk("rst_be", bus.local_be, 0);
    chk("rst_p0_wreq", bus.p0_wdata_req, 0);
    chk("rst_p0_rval", bus.p0_rdata_valid, 0);

    // 1: p0 read size 2
    reset = 0;
    bus.p0_read_req = 1; bus.p0_address = 24'h000123; bus.p0_size = 2;
    step(); #1;
    chk("s1_rd_req", bus.local_read_req, 1);
    chk("s1_bb", bus.local_burstbegin, 1);
    chk("s1_addr", bus.local_address, 24'h000123);
    chk("s1_size", bus.local_size, 2);
    chk("s1_p0_ack", bus.p0_ack, 1);
    chk("s1_p1_ack", bus.p1_ack, 0);
    chk("s1_wr_req", bus.local_write_req, 0);
    bus.p0_read_req = 0;
    step(); #1;
    chk("s1_rd_req_off", bus.local_read_req, 0);
    chk("s1_bb_off", bus.local_burstbegin, 0);
    chk("s1_ack_off", bus.p0_ack, 0);
    bus.local_rdata_valid = 1; bus.local_rdata = 32'hAAAA0001; #1;
    chk("s1_b0_p0v", bus.p0_rdata_valid, 1);
    chk("s1_b0_p1v", bus.p1_rdata_valid, 0);
    chk("s1_b0_p0d", bus.p0_rdata, 32'hAAAA0001);
    chk("s1_b0_p1d", bus.p1_rdata, 32'hAAAA0001);
    step(); bus.local_rdata = 32'hAAAA0002; #1;
    chk("s1_b1_p0v", bus.p0_rdata_valid, 1);
    chk("s1_b1_p1v", bus.p1_rdata_valid, 0);
    step(); #1;
    chk("s1_drop_p0v", bus.p0_rdata_valid, 0);
    chk("s1_drop_p1v", bus.p1_rdata_valid, 0);
    bus.local_rdata_valid = 0;

    // 2: simultaneous writes alternate p0,p1,p0,p1
    reset = 1; step(); reset = 0;
    bus.p0_write_req = 1; bus.p0_address = 24'h000100; bus.p0_size = 1;
    bus.p0_wdata = 32'h11110000; bus.p0_be = 4'h3;
    bus.p1_write_req = 1; bus.p1_address = 24'h000200; bus.p1_size = 1;
    bus.p1_wdata = 32'h22220000; bus.p1_be = 4'hC;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk("s2_wr_req", bus.local_write_req, 1);
      chk("s2_bb", bus.local_burstbegin, 1);
      chk("s2_addr", bus.local_address, (i % 2 == 0) ? 24'h000100 : 24'h000200);
      chk("s2_p0_ack", bus.p0_ack, (i % 2 == 0));
      chk("s2_p1_ack", bus.p1_ack, (i % 2 == 1));
      if (i == 3) begin bus.p0_write_req = 0; bus.p1_write_req = 0; end
      step(); #1;
      chk("s2_wr_req_off", bus.local_write_req, 0);
    end
    bus.local_wdata_req = 1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("s2_p0_wreq", bus.p0_wdata_req, (i % 2 == 0));
      chk("s2_p1_wreq", bus.p1_wdata_req, (i % 2 == 1));
      if (i > 0) begin
        chk("s2_wdata", bus.local_wdata, (i % 2 == 1) ? 32'h11110000 : 32'h22220000);
        chk("s2_be", bus.local_be, (i % 2 == 1) ? 4'h3 : 4'hC);
      end
      step(); #1;
    end
    chk("s2_empty_p0_wreq", bus.p0_wdata_req, 0);
    chk("s2_empty_p1_wreq", bus.p1_wdata_req, 0);
    chk("s2_last_wdata", bus.local_wdata, 32'h22220000);
    chk("s2_last_be", bus.local_be, 4'hC);
    bus.local_wdata_req = 0;
    step(); #1;
    chk("s2_wdata_idle", bus.local_wdata, 0);

    // 3: local_ready low for 5 CMD cycles
    bus.local_ready = 0;
    bus.p1_read_req = 1; bus.p1_address = 24'h3ABCDE; bus.p1_size = 3;
    step(); #1;
    chk("s3_rd_req", bus.local_read_req, 1);
    chk("s3_bb", bus.local_burstbegin, 1);
    chk("s3_ack", bus.p1_ack, 0);
    for (int k = 1; k < 5; k++) begin
      step(); #1;
      chk("s3_hold_req", bus.local_read_req, 1);
      chk("s3_hold_bb", bus.local_burstbegin, 0);
      chk("s3_hold_addr", bus.local_address, 24'h3ABCDE);
      chk("s3_hold_ack", bus.p1_ack, 0);
    end
    bus.local_ready = 1; #1;
    chk("s3_ack_ready", bus.p1_ack, 1);
    chk("s3_size", bus.local_size, 3);
    bus.p1_read_req = 0;
    step(); #1;
    chk("s3_req_off", bus.local_read_req, 0);
    bus.local_rdata_valid = 1; #1;
    for (int k = 0; k < 3; k++) begin
      chk("s3_p1v", bus.p1_rdata_valid, 1);
      chk("s3_p0v", bus.p0_rdata_valid, 0);
      step(); #1;
    end
    chk("s3_drained", bus.p1_rdata_valid, 0);
    bus.local_rdata_valid = 0;

    // 4: read FIFO full blocks reads only
    bus.p0_read_req = 1; bus.p0_address = 24'h000400; bus.p0_size = 1;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      chk("s4_rd_ack", bus.p0_ack, 1);
      if (i == 7) begin bus.p1_write_req = 1; bus.p1_address = 24'h000555; bus.p1_size = 1; end
      step(); #1;
    end
    step(); #1;
    chk("s4_wr_gnt", bus.local_write_req, 1);
    chk("s4_wr_p1_ack", bus.p1_ack, 1);
    chk("s4_wr_p0_ack", bus.p0_ack, 0);
    chk("s4_wr_addr", bus.local_address, 24'h000555);
    chk("s4_no_rd", bus.local_read_req, 0);
    bus.p1_write_req = 0;
    step(); #1;
    step(); #1;
    chk("s4_full_rd", bus.local_read_req, 0);
    chk("s4_full_ack", bus.p0_ack, 0);
    bus.local_rdata_valid = 1; #1;
    chk("s4_pop_p0v", bus.p0_rdata_valid, 1);
    step(); bus.local_rdata_valid = 0; #1;
    chk("s4_still_idle", bus.local_read_req, 0);
    step(); #1;
    chk("s4_9th_rd", bus.local_read_req, 1);
    chk("s4_9th_ack", bus.p0_ack, 1);
    bus.p0_read_req = 0;
    step(); #1;

    // 5: interleaved write/read steering, then reset mid-burst
    reset = 1; step(); reset = 0;
    bus.p0_write_req = 1; bus.p0_address = 24'h000010; bus.p0_size = 3;
    bus.p0_wdata = 32'h0A0A0A0A; bus.p0_be = 4'hF;
    bus.p1_read_req = 1; bus.p1_address = 24'h000020; bus.p1_size = 1;
    step(); #1;
    chk("s5_wr_req", bus.local_write_req, 1);
    chk("s5_wr_size", bus.local_size, 3);
    chk("s5_p0_ack", bus.p0_ack, 1);
    chk("s5_p1_ack0", bus.p1_ack, 0);
    bus.p0_write_req = 0;
    step(); #1;
    step(); #1;
    chk("s5_rd_req", bus.local_read_req, 1);
    chk("s5_p1_ack", bus.p1_ack, 1);
    chk("s5_rd_addr", bus.local_address, 24'h000020);
    bus.p1_read_req = 0;
    step(); #1;
    bus.local_wdata_req = 1; bus.local_rdata_valid = 1; bus.local_rdata = 32'h0000BEEF; #1;
    chk("s5_p0_wreq", bus.p0_wdata_req, 1);
    chk("s5_p1_wreq", bus.p1_wdata_req, 0);
    chk("s5_p1v", bus.p1_rdata_valid, 1);
    chk("s5_p0v", bus.p0_rdata_valid, 0);
    step(); bus.local_rdata_valid = 0; #1;
    chk("s5_p0_wreq2", bus.p0_wdata_req, 1);
    chk("s5_wdata", bus.local_wdata, 32'h0A0A0A0A);
    chk("s5_p1v_done", bus.p1_rdata_valid, 0);
    reset = 1; #1;
    chk("s5_rst_wreq", bus.p0_wdata_req, 0);
    chk("s5_rst_wdata", bus.local_wdata, 0);
    chk("s5_rst_be", bus.local_be, 0);
    chk("s5_rst_wr", bus.local_write_req, 0);
    step(); reset = 0; #1;
    chk("s5_post_wreq", bus.p0_wdata_req, 0);
    bus.local_rdata_valid = 1; #1;
    chk("s5_post_p1v", bus.p1_rdata_valid, 0);
    chk("s5_post_p0v", bus.p0_rdata_valid, 0);
    bus.local_wdata_req = 0; bus.local_rdata_valid = 0;

`ifdef DDR2_ARB_PORT0_PRIORITY_EN
    // 6: port-0 priority with starvation guard
    reset = 1; step(); reset = 0;
    bus.local_rdata_valid = 1;
    bus.p0_read_req = 1; bus.p0_address = 24'h000700; bus.p0_size = 1;
    bus.p1_read_req = 1; bus.p1_address = 24'h000800; bus.p1_size = 1;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      chk("s6_p0_ack", bus.p0_ack, 1);
      step(); #1;
    end
    step(); #1;
    chk("s6_p1_ack", bus.p1_ack, 1);
    chk("s6_p0_ack_off", bus.p0_ack, 0);
    bus.p0_read_req = 0; bus.p1_read_req = 0; bus.local_rdata_valid = 0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
